// File: rtl/csr_hpm_unit.sv
// Machine-mode hardware performance monitor: mhpmcounter/mhpmevent/mcountinhibit CSRs
// with per-counter sticky overflow flags and an overflow interrupt.
module csr_hpm_unit #(
    parameter int unsigned NUM_CNT    = 4,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic [11:0]           addr_i,
    input  logic [31:0]           data_i,
    input  logic [1:0]            op_i,
    input  logic                  we_i,
    output logic [31:0]           data_o,
    output logic                  hit_o,
    output logic                  ill_o,
    output logic                  ovf_irq_o
);

    localparam int unsigned HI_W = CNT_WIDTH - 32;
    localparam int unsigned EV_W = 256;

    localparam logic [11:0] ADDR_CNT_LO  = 12'hB00;
    localparam logic [11:0] ADDR_CNT_HI  = 12'hB80;
    localparam logic [11:0] ADDR_EVT     = 12'h320;
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_USR_LO  = 12'hC00;
    localparam logic [11:0] ADDR_USR_HI  = 12'hC80;

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;
    localparam logic [1:0] OP_RO = 2'b11;

    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CNT];
    logic [7:0]           sel_q  [NUM_CNT];
    logic [7:0]           sel_d  [NUM_CNT];
    logic [NUM_CNT-1:0]   ofie_q, ofie_d;
    logic [NUM_CNT-1:0]   of_q,   of_d;
    logic [NUM_CNT-1:0]   ir_q,   ir_d;

    logic [31:0]          rv_c;
    logic [31:0]          wv_c;
    logic                 hit_c;
    logic                 ro_c;
    logic                 wen_c;
    logic                 inh_hit_c;
    logic [NUM_CNT-1:0]   lo_hit_c, hi_hit_c, evt_hit_c;
    logic [NUM_CNT-1:0]   inc_c, wrap_c, hw_of_c;
    logic [EV_W-1:0]      ev_ext_c;

    // Bit 0 stays zero so SEL=0 and SEL>NUM_EVENTS index a constant-zero bit.
    assign ev_ext_c = EV_W'({events_i, 1'b0});

    // Address decode and read mux.
    always_comb begin
        hit_c     = 1'b0;
        ro_c      = 1'b0;
        rv_c      = '0;
        inh_hit_c = 1'b0;
        lo_hit_c  = '0;
        hi_hit_c  = '0;
        evt_hit_c = '0;
        if (addr_i == ADDR_INHIBIT) begin
            hit_c     = 1'b1;
            inh_hit_c = 1'b1;
            rv_c      = 32'({ir_q, 3'b000});
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (addr_i == ADDR_CNT_LO + 12'(i + 3)) begin
                hit_c       = 1'b1;
                lo_hit_c[i] = 1'b1;
                rv_c        = cnt_q[i][31:0];
            end
            if (addr_i == ADDR_CNT_HI + 12'(i + 3)) begin
                hit_c       = 1'b1;
                hi_hit_c[i] = 1'b1;
                rv_c        = 32'(cnt_q[i][CNT_WIDTH-1:32]);
            end
            if (addr_i == ADDR_EVT + 12'(i + 3)) begin
                hit_c        = 1'b1;
                evt_hit_c[i] = 1'b1;
                rv_c         = {of_q[i], ofie_q[i], 22'b0, sel_q[i]};
            end
            if (addr_i == ADDR_USR_LO + 12'(i + 3)) begin
                hit_c = 1'b1;
                ro_c  = 1'b1;
                rv_c  = cnt_q[i][31:0];
            end
            if (addr_i == ADDR_USR_HI + 12'(i + 3)) begin
                hit_c = 1'b1;
                ro_c  = 1'b1;
                rv_c  = 32'(cnt_q[i][CNT_WIDTH-1:32]);
            end
        end
    end

    // Read-modify-write value.
    always_comb begin
        wv_c = rv_c;
        case (op_i)
            OP_RW:   wv_c = data_i;
            OP_RS:   wv_c = rv_c | data_i;
            OP_RC:   wv_c = rv_c & ~data_i;
            default: wv_c = rv_c;
        endcase
    end

    assign wen_c = we_i && (op_i != OP_RO) && hit_c && !ro_c;

    // Per-counter increment qualification and overflow detection.
    always_comb begin
        inc_c   = '0;
        wrap_c  = '0;
        hw_of_c = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            inc_c[i]   = ev_ext_c[sel_q[i]] && !ir_q[i];
            wrap_c[i]  = &cnt_q[i];
            // A same-cycle write to either half swallows the increment and its overflow.
            hw_of_c[i] = inc_c[i] && wrap_c[i] && !(wen_c && (lo_hit_c[i] || hi_hit_c[i]));
        end
    end

    // Next-state for counters, event selectors and inhibit.
    always_comb begin
        ofie_d = ofie_q;
        of_d   = of_q;
        ir_d   = ir_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
        end
        if (wen_c && inh_hit_c) begin
            ir_d = wv_c[3 +: NUM_CNT];
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (wen_c && lo_hit_c[i]) begin
                cnt_d[i][31:0] = wv_c;
            end else if (wen_c && hi_hit_c[i]) begin
                cnt_d[i][CNT_WIDTH-1:32] = wv_c[HI_W-1:0];
            end else if (inc_c[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
            if (wen_c && evt_hit_c[i]) begin
                sel_d[i]  = wv_c[7:0];
                ofie_d[i] = wv_c[30];
                of_d[i]   = wv_c[31] | hw_of_c[i];
            end else if (hw_of_c[i]) begin
                of_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ofie_q <= '0;
            of_q   <= '0;
            ir_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            ofie_q <= ofie_d;
            of_q   <= of_d;
            ir_q   <= ir_d;
        end
    end

    assign data_o    = rv_c;
    assign hit_o     = hit_c;
    assign ill_o     = rst_ni && we_i && (op_i != OP_RO) && ro_c;
    assign ovf_irq_o = |(of_q & ofie_q);

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Scoreboard bench for csr_hpm_unit: expectations queued with each stimulus step,
// drained against the DUT outputs mid-cycle.
module tb_csr_hpm_unit;

    localparam int unsigned NUM_CNT    = 4;
    localparam int unsigned NUM_EVENTS = 8;

    localparam int unsigned SIG_DATA   = 0;
    localparam int unsigned SIG_HIT    = 1;
    localparam int unsigned SIG_ILL    = 2;
    localparam int unsigned SIG_IRQ    = 3;
    localparam int unsigned SIG_DATA40 = 4;
    localparam int unsigned SIG_IRQ40  = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NUM_EVENTS-1:0] events_i;
    logic [11:0]           addr_i;
    logic [31:0]           data_i;
    logic [1:0]            op_i;
    logic                  we_i;
    logic [31:0]           data_o,    data40_o;
    logic                  hit_o,     hit40_o;
    logic                  ill_o,     ill40_o;
    logic                  ovf_irq_o, ovf_irq40_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    string       tag_q[$];
    int unsigned sig_q[$];
    logic [31:0] exp_q[$];

    csr_hpm_unit #(.NUM_CNT(NUM_CNT), .CNT_WIDTH(64), .NUM_EVENTS(NUM_EVENTS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .events_i(events_i), .addr_i(addr_i),
        .data_i(data_i), .op_i(op_i), .we_i(we_i), .data_o(data_o),
        .hit_o(hit_o), .ill_o(ill_o), .ovf_irq_o(ovf_irq_o)
    );

    csr_hpm_unit #(.NUM_CNT(NUM_CNT), .CNT_WIDTH(40), .NUM_EVENTS(NUM_EVENTS)) dut40 (
        .clk_i(clk_i), .rst_ni(rst_ni), .events_i(events_i), .addr_i(addr_i),
        .data_i(data_i), .op_i(op_i), .we_i(we_i), .data_o(data40_o),
        .hit_o(hit40_o), .ill_o(ill40_o), .ovf_irq_o(ovf_irq40_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int unsigned sig);
        case (sig)
            SIG_DATA:   return data_o;
            SIG_HIT:    return 32'(hit_o);
            SIG_ILL:    return 32'(ill_o);
            SIG_IRQ:    return 32'(ovf_irq_o);
            SIG_DATA40: return data40_o;
            SIG_IRQ40:  return 32'(ovf_irq40_o);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int unsigned sig, input logic [31:0] exp);
        tag_q.push_back(tag);
        sig_q.push_back(sig);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        #2;
        while (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), observe(sig_q.pop_front()), exp_q.pop_front());
        end
    endtask

    task automatic set_addr(input logic [11:0] addr);
        @(negedge clk_i);
        addr_i = addr;
        we_i   = 1'b0;
        op_i   = 2'b11;
    endtask

    task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp,
                            input logic hit, input string tag);
        set_addr(addr);
        expect_out(tag, SIG_DATA, exp);
        expect_out({tag, "_hit"}, SIG_HIT, 32'(hit));
        drain();
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data, input logic [1:0] op);
        @(negedge clk_i);
        addr_i = addr;
        data_i = data;
        op_i   = op;
        we_i   = 1'b1;
        @(negedge clk_i);
        we_i   = 1'b0;
        op_i   = 2'b11;
    endtask

    task automatic pulse(input logic [NUM_EVENTS-1:0] ev, input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            @(negedge clk_i);
            events_i = ev;
            @(negedge clk_i);
            events_i = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni   = 1'b0;
        events_i = '0;
        addr_i   = 12'hC03;
        data_i   = '0;
        op_i     = 2'b00;
        we_i     = 1'b1;
        repeat (2) @(negedge clk_i);
        expect_out("rst_irq", SIG_IRQ, 32'd0);
        expect_out("rst_ill", SIG_ILL, 32'd0);
        drain();
        we_i = 1'b0;
        op_i = 2'b11;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state readback
        csr_read(12'hB03, 32'd0, 1'b1, "rst_cnt_lo");
        csr_read(12'hB83, 32'd0, 1'b1, "rst_cnt_hi");
        csr_read(12'h323, 32'd0, 1'b1, "rst_evt");
        csr_read(12'h320, 32'd0, 1'b1, "rst_inh");
        csr_read(12'(32'hB00 + 3 + NUM_CNT), 32'd0, 1'b0, "unmapped");

        // Counting and inhibit
        csr_write(12'h323, 32'h2, 2'b00);
        pulse(8'h02, 5);
        csr_read(12'hB03, 32'd5, 1'b1, "count5");
        csr_write(12'h320, 32'h8, 2'b00);
        csr_read(12'h320, 32'h8, 1'b1, "inh_set");
        pulse(8'h02, 3);
        csr_read(12'hB03, 32'd5, 1'b1, "inhibited");
        pulse(8'h01, 3);
        csr_read(12'hB03, 32'd5, 1'b1, "other_event");
        csr_write(12'h320, 32'h0, 2'b00);

        // Overflow
        csr_write(12'hB83, 32'hFFFF_FFFF, 2'b00);
        set_addr(12'hB83);
        expect_out("hi64", SIG_DATA, 32'hFFFF_FFFF);
        expect_out("hi40_trunc", SIG_DATA40, 32'h0000_00FF);
        drain();
        csr_write(12'hB03, 32'hFFFF_FFFE, 2'b00);
        csr_write(12'h323, 32'h4000_0001, 2'b00);
        pulse(8'h01, 1);
        csr_read(12'hB03, 32'hFFFF_FFFF, 1'b1, "pre_wrap");
        set_addr(12'h323);
        expect_out("pre_wrap_evt", SIG_DATA, 32'h4000_0001);
        expect_out("pre_wrap_irq", SIG_IRQ, 32'd0);
        drain();
        pulse(8'h01, 1);
        csr_read(12'hB03, 32'd0, 1'b1, "wrap_lo");
        csr_read(12'hB83, 32'd0, 1'b1, "wrap_hi");
        set_addr(12'h323);
        expect_out("of_set", SIG_DATA, 32'hC000_0001);
        expect_out("irq_set", SIG_IRQ, 32'd1);
        expect_out("irq40_set", SIG_IRQ40, 32'd1);
        drain();
        csr_write(12'h323, 32'h8000_0000, 2'b10);
        set_addr(12'h323);
        expect_out("of_clr", SIG_DATA, 32'h4000_0001);
        expect_out("irq_clr", SIG_IRQ, 32'd0);
        drain();

        // Write beats a same-cycle increment
        @(negedge clk_i);
        addr_i   = 12'hB03;
        data_i   = 32'h100;
        op_i     = 2'b00;
        we_i     = 1'b1;
        events_i = 8'h01;
        @(negedge clk_i);
        we_i     = 1'b0;
        op_i     = 2'b11;
        events_i = '0;
        csr_read(12'hB03, 32'h100, 1'b1, "collision");
        pulse(8'h01, 1);
        csr_read(12'hB03, 32'h101, 1'b1, "post_collision");

        // RS/RC on inhibit, implemented-bit masking
        csr_write(12'h320, 32'h10, 2'b01);
        csr_read(12'h320, 32'h10, 1'b1, "inh_rs");
        csr_write(12'h320, 32'h10, 2'b10);
        csr_read(12'h320, 32'h0, 1'b1, "inh_rc");
        csr_write(12'h320, 32'hFFFF_FFFF, 2'b01);
        csr_read(12'h320, 32'h78, 1'b1, "inh_mask");
        csr_write(12'h320, 32'hFFFF_FFFF, 2'b10);

        // Illegal write to a user shadow
        @(negedge clk_i);
        addr_i = 12'hC03;
        data_i = 32'h0;
        op_i   = 2'b00;
        we_i   = 1'b1;
        expect_out("ill_set", SIG_ILL, 32'd1);
        expect_out("ill_hit", SIG_HIT, 32'd1);
        expect_out("ill_shadow", SIG_DATA, 32'h101);
        drain();
        @(negedge clk_i);
        we_i = 1'b0;
        op_i = 2'b11;
        expect_out("ill_clr", SIG_ILL, 32'd0);
        drain();
        csr_read(12'hB03, 32'h101, 1'b1, "ill_nochange");
        csr_read(12'hC83, 32'h0, 1'b1, "shadow_hi");

        // Asynchronous reset while events stream
        @(negedge clk_i);
        addr_i   = 12'hB03;
        events_i = 8'h01;
        repeat (3) @(negedge clk_i);
        expect_out("stream", SIG_DATA, 32'h104);
        drain();
        rst_ni = 1'b0;
        expect_out("async_rst_cnt", SIG_DATA, 32'd0);
        expect_out("async_rst_hit", SIG_HIT, 32'd1);
        drain();
        repeat (2) @(negedge clk_i);
        expect_out("rst_hold", SIG_DATA, 32'd0);
        drain();
        csr_read(12'h323, 32'd0, 1'b1, "rst_hold_evt");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        csr_read(12'hB03, 32'd0, 1'b1, "post_rst_idle");
        events_i = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_hpm_unit.md
# csr_hpm_unit

Parametrised machine-mode hardware performance monitor (HPM) block that implements mhpmcounter3..(3+NUM_CNT-1), their high halves, mhpmevent selectors, mcountinhibit and read-only user shadows. It sits beside the core CSR unit on the same CSR access bus, counting pipeline event pulses, and it adds per-counter overflow flags with an interrupt output. The core CSR unit forwards an access here whenever `hit_o` is high.

## Interface
- `NUM_CNT`, 4: number of HPM counters, 1..29 (indices 3..3+NUM_CNT-1).
- `CNT_WIDTH`, 64: implemented counter width, 33..64. Bits above it read 0 and ignore writes.
- `NUM_EVENTS`, 8: number of event inputs, 1..255.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `events_i`  in  NUM_EVENTS  single-cycle event pulses. Bit k is event number k+1.
- `addr_i`  in  12  CSR address.
- `data_i`  in  32  CSR operand.
- `op_i`  in  2  00 RW, 01 RS, 10 RC, 11 read-only.
- `we_i`  in  1  write request qualifier.
- `data_o`  out  32  read value of the addressed CSR (combinational).
- `hit_o`  out  1  addr_i decodes to a CSR owned by this block.
- `ill_o`  out  1  we_i with op_i≠11 to a read-only address in this block.
- `ovf_irq_o`  out  1  OR over i of (OF_i & OFIE_i).

## Operation
- Address map, for i in 0..NUM_CNT-1 and n=3+i:
  - mhpmcounter n at 0xB00+n (low 32 bits).
  - mhpmcounterh n at 0xB80+n.
  - mhpmevent n at 0x320+n.
  - mcountinhibit at 0x320.
  - User shadows hpmcounter n at 0xC00+n and hpmcounterh n at 0xC80+n are read-only.
- Unmapped address: `hit_o`=0, `data_o`=0, no state change.
- Write value `wv`, where `rv` is the current read value:
  - RW: `wv` = `data_i`.
  - RS: `wv` = `rv` | `data_i`.
  - RC: `wv` = `rv` & ~`data_i`.
  - 11: no write.
  - A write occurs when `we_i` is 1, op_i≠11, `hit_o` is 1 and the address is writable.
- mhpmevent n fields:
  - [7:0] SEL. 0 or >NUM_EVENTS selects no event.
  - [30] OFIE.
  - [31] OF, sticky.
  - All other bits read 0.
- mcountinhibit: bit n is HPM inhibit IR_n. Bits 0..2 and any unimplemented bits read 0 and ignore writes.
- Increment condition: counter i increments by 1 when events_i[SEL_i-1] is 1, SEL_i is valid and IR_n is 0.
- Wrap-around: an increment at all-ones (CNT_WIDTH bits) yields 0 and sets OF_i.
- Write to the low half replaces bits [31:0] only. Write to the high half replaces bits [CNT_WIDTH-1:32] only.
- A CSR write and an increment on the same counter in the same cycle: the write wins and that increment is lost. No OF is set from the lost increment.
- A hardware OF set and a software write of OF in the same cycle: the hardware set wins (OF=1). The other fields take `wv`.
- `ill_o` rises on the write attempt to a read-only address. No state changes.
- Reset (rst_ni low, any time, including mid-count):
  - All counters, SEL, OFIE, OF and IR clear to 0 immediately.
  - `ovf_irq_o`=0 and `ill_o`=0.
  - `data_o` and `hit_o` continue to decode addr_i. Counters read 0.

## Timing
- Read latency 0: `data_o` is valid in the same cycle as addr_i.
- A write takes effect at the next rising edge. A read in the following cycle returns the new value.
- An event pulse in cycle t is visible in `data_o` in cycle t+1.
- OF sets at the edge of the wrapping increment. `ovf_irq_o` rises in the same cycle OF reads 1, because it is combinational from registers.
- A 64-bit read is not atomic. Software reads high, low, high.
- No multicycle paths. Increment carry spans the full CNT_WIDTH within one cycle.

## Test plan
- Reset then read: rst_ni low for 2 cycles, then read 0xB03, 0xB83, 0x323 and 0x320 → all 0, `hit_o`=1. Read 0xB00+3+NUM_CNT → `hit_o`=0, `data_o`=0.
- Counting and inhibit:
  - Write 0x323 = 0x2 (RW), pulse events_i[1] 5 times → 0xB03 reads 5.
  - Write 0x320 = 0x8, pulse 3 more times → still 5.
  - Pulse events_i[0] 3 times → unchanged.
- Overflow:
  - Write 0xB83 = 0xFFFFFFFF, 0xB03 = 0xFFFFFFFE, 0x323 = 0x4000_0001, then pulse events_i[0] twice → counter reads 0.
  - 0x323 reads 0xC000_0001 and `ovf_irq_o`=1.
  - RC write of 0x8000_0000 to 0x323 → `ovf_irq_o`=0.
- Collision: RW write 0x100 to 0xB03 in the same cycle as a counted event → reads 0x100, not 0x101.
- RS/RC and illegal access:
  - RS 0x10 on 0x320 → reads 0x10. RC 0x10 → reads 0.
  - RW write to 0xC03 → `ill_o`=1 and the counter is unchanged.
  - With CNT_WIDTH=40, write 0xB83 = 0xFFFFFFFF → reads 0xFF.
- Async reset mid-count: assert rst_ni low between clock edges while events stream → counters read 0 before the next edge and stay 0 until release.
